// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame format and baud helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int   DATA_BITS   = 8;
  localparam logic PARITY_EVEN = 1'b1;

  function automatic int unsigned cycles_per_bit(input int unsigned clock_freq,
                                                 input int unsigned baud);
    return clock_freq / baud;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-to-RX-FIFO write port: byte, strobe, per-frame status and backpressure.
interface uart_receiver_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_error;
  logic       framing_error;
  logic       overrun_error;
  logic       fifo_full;

  modport master (output rx_data, rx_valid, parity_error, framing_error, overrun_error,
                  input  fifo_full);
  modport slave  (input  rx_data, rx_valid, parity_error, framing_error, overrun_error,
                  output fifo_full);
endinterface

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with selectable reset value.
module uart_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      q      <= RST_VAL;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8E1 UART receiver: mid-bit sampling off a per-bit counter, one write strobe per frame.
//   state     | meaning
//   ST_IDLE   | waiting for a high-to-low edge on the synchronized line
//   ST_START  | counting to mid start bit to reject glitches
//   ST_DATA   | sampling the 8 data bits, LSB first
//   ST_PARITY | sampling the even-parity bit
//   ST_STOP   | sampling the stop bit, then reporting the frame
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD       = 9600
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_line,
  output logic             state_busy,
  uart_receiver_if.master  rx
);

  localparam int unsigned CPB   = cycles_per_bit(CLOCK_FREQ, BAUD);
  localparam int unsigned HALF  = CPB / 2;
  localparam int          CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int          IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  uart_state_t          state_q, state_nxt;
  logic [CNT_W-1:0]     cnt_q, cnt_nxt;
  logic [IDX_W-1:0]     idx_q, idx_nxt;
  logic [DATA_BITS-1:0] shreg_q, shreg_nxt;
  logic                 par_q, par_nxt;
  logic                 rx_s, rx_prev_q;
  logic                 bit_end;
  logic [7:0]           data_q, data_nxt;
  logic                 perr_q, perr_nxt;
  logic                 ferr_q, ferr_nxt;
  logic                 valid_q, valid_nxt;
  logic                 ovr_q, ovr_nxt;

  uart_sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_line),
    .q   (rx_s)
  );

  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      rx_prev_q <= 1'b1;
      data_q    <= 8'h00;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      idx_q     <= idx_nxt;
      shreg_q   <= shreg_nxt;
      par_q     <= par_nxt;
      rx_prev_q <= rx_s;
      data_q    <= data_nxt;
      perr_q    <= perr_nxt;
      ferr_q    <= ferr_nxt;
      valid_q   <= valid_nxt;
      ovr_q     <= ovr_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    idx_nxt   = idx_q;
    shreg_nxt = shreg_q;
    par_nxt   = par_q;
    data_nxt  = data_q;
    perr_nxt  = perr_q;
    ferr_nxt  = ferr_q;
    valid_nxt = 1'b0;
    ovr_nxt   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A line stuck low after a bad stop bit has no edge, so it cannot restart a frame.
        if (rx_prev_q && !rx_s) begin
          state_nxt = ST_START;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_MID) begin
          cnt_nxt   = '0;
          state_nxt = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_nxt[idx_q] = rx_s;
          idx_nxt          = idx_q + 1'b1;
          cnt_nxt          = '0;
          if (idx_q == IDX_LAST) state_nxt = ST_PARITY;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          par_nxt   = rx_s;
          cnt_nxt   = '0;
          state_nxt = ST_STOP;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
          data_nxt  = shreg_q;
          perr_nxt  = (^{shreg_q, par_q}) ^ ~PARITY_EVEN;
          ferr_nxt  = ~rx_s;
          valid_nxt = ~rx.fifo_full;
          ovr_nxt   = rx.fifo_full;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign state_busy       = (state_q != ST_IDLE);
  assign rx.rx_data       = data_q;
  assign rx.rx_valid      = valid_q;
  assign rx.parity_error  = perr_q;
  assign rx.framing_error = ferr_q;
  assign rx.overrun_error = ovr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at 16 clocks per bit, scoreboard-driven.
module tb_uart_receiver;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rx_line;
  logic state_busy;

  uart_receiver_if rx_if ();

  uart_receiver #(.CLOCK_FREQ(16), .BAUD(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_line    (rx_line),
    .state_busy (state_busy),
    .rx         (rx_if.master)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_vec    = 0;
  int   n_err    = 0;
  int   n_strobe = 0;
  int   n_pushed = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every strobe must match the oldest expected frame.
  always @(negedge clk) begin
    if (!rst && (rx_if.rx_valid || rx_if.overrun_error)) begin
      n_strobe++;
      if (exp_q.size() == 0) begin
        check_val("spurious_strobe", {30'd0, rx_if.rx_valid, rx_if.overrun_error}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("strobe_kind", {30'd0, rx_if.rx_valid, rx_if.overrun_error},
                  e.ovr ? 32'd1 : 32'd2);
        check_val("rx_data", {24'd0, rx_if.rx_data}, {24'd0, e.data});
        check_val("parity_error", {31'd0, rx_if.parity_error}, {31'd0, e.perr});
        check_val("framing_error", {31'd0, rx_if.framing_error}, {31'd0, e.ferr});
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx_line = b;
    wait_cyc(16);
  endtask

  // Leaves the line at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input logic ovr);
    exp_t e;
    e.data = d;
    e.perr = (^d) ^ par;
    e.ferr = ~stp;
    e.ovr  = ovr;
    exp_q.push_back(e);
    n_pushed++;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stp);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_busy;
    int strobe_mark;
    logic [7:0] b;

    rst              = 1'b1;
    rx_line          = 1'b1;
    rx_if.fifo_full  = 1'b0;
    wait_cyc(3);
    check_val("rst_rx_data", {24'd0, rx_if.rx_data}, 32'd0);
    check_val("rst_rx_valid", {31'd0, rx_if.rx_valid}, 32'd0);
    check_val("rst_parity_error", {31'd0, rx_if.parity_error}, 32'd0);
    check_val("rst_framing_error", {31'd0, rx_if.framing_error}, 32'd0);
    check_val("rst_overrun_error", {31'd0, rx_if.overrun_error}, 32'd0);
    check_val("rst_state_busy", {31'd0, state_busy}, 32'd0);
    rst = 1'b0;
    wait_cyc(5);

    // Clean frame, then a bad-parity frame.
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    wait_cyc(4);
    send_frame(8'h01, 1'b0, 1'b1, 1'b0);
    wait_cyc(4);

    // Stop bit low, line held low: one strobe, no restart until a fresh edge.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    wait_cyc(40);
    check_val("held_low_busy", {31'd0, state_busy}, 32'd0);
    check_val("held_low_pending", exp_q.size(), 32'd0);
    rx_line = 1'b1;
    wait_cyc(20);
    send_frame(8'h77, 1'b0, 1'b1, 1'b0);
    wait_cyc(4);

    // Short low glitch on idle line.
    n_busy = 0;
    rx_line = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 4) rx_line = 1'b1;
      @(negedge clk);
      if (state_busy) n_busy++;
    end
    check_val("glitch_busy_seen", {31'd0, n_busy > 0}, 32'd1);
    check_val("glitch_busy_le10", {31'd0, n_busy <= 10}, 32'd1);

    // FIFO full: overrun pulse, byte still reported on rx_data.
    rx_if.fifo_full = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
    wait_cyc(4);
    rx_if.fifo_full = 1'b0;
    check_val("overrun_data_held", {24'd0, rx_if.rx_data}, 32'h5A);

    // Reset in the middle of data bit 3 of 0xFF.
    strobe_mark = n_strobe;
    rx_line = 1'b0;
    wait_cyc(16);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    wait_cyc(8);
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    rx_line = 1'b1;
    wait_cyc(5);
    check_val("abort_busy", {31'd0, state_busy}, 32'd0);
    check_val("abort_rx_data", {24'd0, rx_if.rx_data}, 32'd0);
    send_frame(8'h12, 1'b0, 1'b1, 1'b0);
    wait_cyc(4);
    check_val("abort_one_strobe", n_strobe - strobe_mark, 32'd1);
    check_val("abort_rx_data_after", {24'd0, rx_if.rx_data}, 32'h12);

    // Loopback of random bytes with correct parity.
    for (int k = 0; k < 16; k++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, ^b, 1'b1, 1'b0);
      wait_cyc($urandom_range(1, 6));
    end

    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
    check_val("queue_drained", exp_q.size(), 32'd0);
    check_val("strobe_total", n_strobe, n_pushed);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLOCK_FREQ, default 50_000_000, clk frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line bit rate.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rx_line  input  1  asynchronous UART serial line; idles high.
REQ-006 fifo_full  input  1  downstream RX FIFO cannot accept a write.
REQ-007 rx_data  output  8  last received byte, held until next frame completes.
REQ-008 rx_valid  output  1  one-cycle write strobe to RX FIFO; rx_data valid that cycle.
REQ-009 parity_error  output  1  parity result of the frame reported with the last rx_valid or overrun_error.
REQ-010 framing_error  output  1  stop-bit result of that same frame.
REQ-011 overrun_error  output  1  one-cycle pulse: frame complete while fifo_full=1; byte dropped.
REQ-012 state_busy  output  1  high whenever FSM is not IDLE.

Function
REQ-013 Frame format SHALL be 1 start (0), 8 data LSB first, 1 even-parity bit, 1 stop (1).
REQ-014 CPB SHALL equal CLOCK_FREQ/BAUD (integer divide); HALF SHALL equal CPB/2.
REQ-015 rx_line SHALL pass through a 2-FF synchronizer before any use; 2 cycles of input latency.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE -> START on synchronized falling edge (previous sample 1, current 0); bit counter cleared.
REQ-018 START: count 0..HALF-1; at HALF-1 sample line: 0 -> DATA with counter cleared, 1 -> IDLE (false start, no outputs change).
REQ-019 DATA: sample at counter CPB-1 into bit rx_index (0..7), rx_index increments; after bit 7 -> PARITY.
REQ-020 PARITY: sample at CPB-1; parity_error computed as XOR of 8 data bits XOR sampled parity bit; -> STOP.
REQ-021 STOP: sample at CPB-1; framing_error = NOT sampled bit; -> IDLE in the same transition.
REQ-022 Cycle after the stop sample: rx_data, parity_error, framing_error update; rx_valid=1 if fifo_full=0, else overrun_error=1; exactly one of the two pulses per completed frame.
REQ-023 Frames with parity or framing errors SHALL still be written (rx_valid) with the flags set.
REQ-024 After a stop bit sampled 0, IDLE SHALL not start a new frame until line returns high and falls again.
REQ-025 Bit counter SHALL be wide enough for CPB-1 and SHALL never wrap within a bit period.
REQ-026 rst mid-frame SHALL abort the frame with no strobe and no flag change beyond reset values.

Reset
REQ-027 On rst: state IDLE, counters 0, synchronizer FFs 1, rx_data 8'h00, rx_valid 0, parity_error 0, framing_error 0, overrun_error 0, state_busy 0.
REQ-028 First frame SHALL be detectable no earlier than 3 cycles after rst deassertion.

Structure
REQ-029 Package uart_pkg SHALL hold the state enum, the frame-format constants (data bits 8, even parity) and a cycles-per-bit function shared with the transmitter.
REQ-030 Sub-module uart_sync_2ff (parameterized reset value 1) SHALL implement the synchronizer; everything else lives in uart_receiver.

Verification (CLOCK_FREQ=16, BAUD=1: CPB=16, HALF=8)
REQ-031 Send 0xA5, parity 0, stop 1 -> one rx_valid, rx_data=8'hA5, both error flags 0.
REQ-032 Send 0x01 with parity bit 0 -> rx_valid, rx_data=8'h01, parity_error=1.
REQ-033 Send 0x3C with stop bit 0 and the line then held low for 40 cycles -> rx_valid, framing_error=1, no second frame until line rises then falls.
REQ-034 Low glitch of 4 cycles on idle line -> back to IDLE, no rx_valid, state_busy high for at most 10 cycles.
REQ-035 Send 0x5A with fifo_full=1 -> overrun_error pulse, no rx_valid, rx_data=8'h5A.
REQ-036 Assert rst during data bit 3 of 0xFF, then send 0x12 -> only one strobe, rx_data=8'h12; also loopback transmitter to receiver, 16 random bytes match in order.
